usi_csr_master: RTL and testbench

USI_CSR_MASTER -- requirements
Module: usi_csr_master

---
 rtl/usi_bus_pkg.sv | 47 ++++
 rtl/usi_timeout_timer.sv | 34 +++
 rtl/usi_csr_master.sv | 140 ++++++++++++++
 tb/tb_usi_csr_master.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/usi_bus_pkg.sv
// usi_bus_pkg: shared definitions for the USI CSR bus.
//   - command codes driven in oSUsiAdrs[31:30]
//   - address field positions/widths (cmd 31:30, block 19:16, register 15:0)
//   - CSR master FSM state encoding
//   - usi_adrs(): packs a bus address word from its fields
package usi_bus_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned ADRS_W  = 32;
  localparam int unsigned CMD_W   = 2;
  localparam int unsigned CMD_MSB = 31;
  localparam int unsigned CMD_LSB = 30;
  localparam int unsigned BLK_W   = 4;
  localparam int unsigned BLK_MSB = 19;
  localparam int unsigned BLK_LSB = 16;
  localparam int unsigned REG_W   = 16;
  localparam int unsigned REG_MSB = 15;
  localparam int unsigned REG_LSB = 0;
  localparam int unsigned TMR_W   = 16;

  // 2'b11 is reserved and never driven.
  typedef enum logic [CMD_W-1:0] {
    CMD_IDLE = 2'b00,
    CMD_WR   = 2'b01,
    CMD_RD   = 2'b10
  } usi_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RSP     = 2'd3
  } usi_state_e;

  // Bus address word: {cmd, 10'd0, block, register}.
  function automatic logic [ADRS_W-1:0] usi_adrs(input usi_cmd_e cmd,
                                                 input logic [BLK_W-1:0] blk,
                                                 input logic [REG_W-1:0] adrs);
    logic [ADRS_W-1:0] v;
    v                   = '0;
    v[CMD_MSB:CMD_LSB]  = cmd;
    v[BLK_MSB:BLK_LSB]  = blk;
    v[REG_MSB:REG_LSB]  = adrs;
    return v;
  endfunction

endpackage

// File: rtl/usi_timeout_timer.sv
// usi_timeout_timer: read-wait cycle counter for the CSR master.
//   i_clk, i_rst_n : clock / async active-low reset
//   i_clear        : force count to zero (held while not waiting)
//   i_enable       : count this cycle
//   o_expire_c     : combinational, high in the pCycles-th enabled cycle
module usi_timeout_timer
  import usi_bus_pkg::*;
#(
  parameter int unsigned pCycles = 255
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire_c
);

  logic [TMR_W-1:0] r_count;

  // Count enabled cycles since the last clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + TMR_W'(1);
    end
  end

  // Count starts at 0 in the first waiting cycle, so cycle k shows k-1.
  assign o_expire_c = i_enable && (r_count == TMR_W'(pCycles - 1));

endmodule

// File: rtl/usi_csr_master.sv
// usi_csr_master: turns single CSR write/read commands into USI bus cycles.
//   iSCLK, inSRST          : clock / async active-low reset
//   iCmdValid/oCmdReady    : command handshake (ready only in IDLE)
//   iCmdWrite, iCmdBlockId, iCmdAdrs, iCmdWd : command payload
//   oRspValid, oRspRd, oRspErr : one-cycle response strobe, held data/flag
//   oSUsiWd, oSUsiAdrs     : USI bus write data / {cmd,0,block,adrs}
//   iSUsiRd, iSUsiREd      : USI read data / read-data-valid
// Optional feature: define USI_CSR_MASTER_TIMEOUT_EN to bound the read wait
// to pTimeoutCycles cycles, answering with oRspErr=1 and oRspRd=pIdleRd.
module usi_csr_master
  import usi_bus_pkg::*;
#(
  parameter int unsigned       pTimeoutCycles = 255,
  parameter logic [DATA_W-1:0] pIdleRd        = 32'h0000_0000
) (
  input  logic              iSCLK,
  input  logic              inSRST,
  input  logic              iCmdValid,
  output logic              oCmdReady,
  input  logic              iCmdWrite,
  input  logic [BLK_W-1:0]  iCmdBlockId,
  input  logic [REG_W-1:0]  iCmdAdrs,
  input  logic [DATA_W-1:0] iCmdWd,
  output logic              oRspValid,
  output logic [DATA_W-1:0] oRspRd,
  output logic              oRspErr,
  output logic [DATA_W-1:0] oSUsiWd,
  output logic [ADRS_W-1:0] oSUsiAdrs,
  input  logic [DATA_W-1:0] iSUsiRd,
  input  logic              iSUsiREd
);

  usi_state_e        r_state, w_state_nxt;
  logic              r_cmd_ready, w_cmd_ready_nxt;
  logic              r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0] r_rsp_rd, w_rsp_rd_nxt;
  logic              r_rsp_err, w_rsp_err_nxt;
  logic [DATA_W-1:0] r_usi_wd, w_usi_wd_nxt;
  logic [ADRS_W-1:0] r_usi_adrs, w_usi_adrs_nxt;
  logic              w_expire_c;

`ifdef USI_CSR_MASTER_TIMEOUT_EN
  usi_timeout_timer #(
    .pCycles (pTimeoutCycles)
  ) u_timeout (
    .i_clk      (iSCLK),
    .i_rst_n    (inSRST),
    .i_clear    (r_state != ST_RD_WAIT),
    .i_enable   (r_state == ST_RD_WAIT),
    .o_expire_c (w_expire_c)
  );
`else
  // Reads wait indefinitely; timeout parameters have no effect.
  logic w_unused;
  assign w_unused   = ^{pIdleRd, TMR_W'(pTimeoutCycles)};
  assign w_expire_c = 1'b0;
`endif

  // State and all outputs are registered; reset drops any in-flight command.
  always_ff @(posedge iSCLK or negedge inSRST) begin
    if (!inSRST) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rd    <= '0;
      r_rsp_err   <= 1'b0;
      r_usi_wd    <= '0;
      r_usi_adrs  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rd    <= w_rsp_rd_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_usi_wd    <= w_usi_wd_nxt;
      r_usi_adrs  <= w_usi_adrs_nxt;
    end
  end

  // Next state and next registered outputs; bus defaults to idle code.
  always_comb begin
    w_state_nxt     = r_state;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_rd_nxt    = r_rsp_rd;
    w_rsp_err_nxt   = r_rsp_err;
    w_usi_wd_nxt    = '0;
    w_usi_adrs_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (iCmdValid && r_cmd_ready) begin
          if (iCmdWrite) begin
            w_state_nxt    = ST_WR;
            w_usi_adrs_nxt = usi_adrs(CMD_WR, iCmdBlockId, iCmdAdrs);
            w_usi_wd_nxt   = iCmdWd;
          end else begin
            w_state_nxt    = ST_RD_WAIT;
            w_usi_adrs_nxt = usi_adrs(CMD_RD, iCmdBlockId, iCmdAdrs);
          end
        end
      end
      ST_WR: begin
        w_state_nxt     = ST_RSP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_rd_nxt    = '0;
        w_rsp_err_nxt   = 1'b0;
      end
      ST_RD_WAIT: begin
        // Read data wins over a timeout landing in the same cycle.
        if (iSUsiREd) begin
          w_state_nxt     = ST_RSP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rd_nxt    = iSUsiRd;
          w_rsp_err_nxt   = 1'b0;
        end else if (w_expire_c) begin
          w_state_nxt     = ST_RSP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rd_nxt    = pIdleRd;
          w_rsp_err_nxt   = 1'b1;
        end else begin
          w_usi_adrs_nxt  = r_usi_adrs;
        end
      end
      ST_RSP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_cmd_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  assign oCmdReady = r_cmd_ready;
  assign oRspValid = r_rsp_valid;
  assign oRspRd    = r_rsp_rd;
  assign oRspErr   = r_rsp_err;
  assign oSUsiWd   = r_usi_wd;
  assign oSUsiAdrs = r_usi_adrs;

endmodule

// File: tb/tb_usi_csr_master.sv
// tb_usi_csr_master: directed self-checking bench for usi_csr_master.
module tb_usi_csr_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_id = 4'd0;
  logic [15:0] cmd_adrs = 16'd0;
  logic [31:0] cmd_wd = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rd;
  logic        rsp_err;
  logic [31:0] usi_wd;
  logic [31:0] usi_adrs;
  logic [31:0] usi_rd = 32'd0;
  logic        usi_red = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  usi_csr_master #(
    .pTimeoutCycles (8),
    .pIdleRd        (32'h0000_0000)
  ) dut (
    .iSCLK       (clk),
    .inSRST      (rst_n),
    .iCmdValid   (cmd_valid),
    .oCmdReady   (cmd_ready),
    .iCmdWrite   (cmd_write),
    .iCmdBlockId (cmd_id),
    .iCmdAdrs    (cmd_adrs),
    .iCmdWd      (cmd_wd),
    .oRspValid   (rsp_valid),
    .oRspRd      (rsp_rd),
    .oRspErr     (rsp_err),
    .oSUsiWd     (usi_wd),
    .oSUsiAdrs   (usi_adrs),
    .iSUsiRd     (usi_rd),
    .iSUsiREd    (usi_red)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    tick();
    tick();
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    n_tests++; if (usi_adrs !== 32'h0) begin n_fail++; $display("FAIL rst_adrs got=%h exp=0", usi_adrs); end
    n_tests++; if ({rsp_rd, rsp_err, usi_wd} !== 65'h0) begin n_fail++; $display("FAIL rst_data got=%h/%b/%h exp=0", rsp_rd, rsp_err, usi_wd); end
    rst_n = 1'b1;
    #1;
    n_tests++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL rel_ready_early got=%b exp=0", cmd_ready); end
    tick();
    n_tests++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_write();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 4'd3; cmd_adrs = 16'h0011; cmd_wd = 32'h2;
    tick();
    cmd_valid = 1'b0;
    n_tests++; if (usi_adrs !== 32'h4003_0011) begin n_fail++; $display("FAIL wr_adrs got=%h exp=40030011", usi_adrs); end
    n_tests++; if (usi_wd !== 32'h2) begin n_fail++; $display("FAIL wr_wd got=%h exp=2", usi_wd); end
    n_tests++; if ({cmd_ready, rsp_valid} !== 2'b00) begin n_fail++; $display("FAIL wr_busy got=%b exp=00", {cmd_ready, rsp_valid}); end
    tick();
    n_tests++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL wr_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    n_tests++; if (rsp_rd !== 32'h0) begin n_fail++; $display("FAIL wr_rsp_rd got=%h exp=0", rsp_rd); end
    n_tests++; if ({usi_adrs, usi_wd} !== 64'h0) begin n_fail++; $display("FAIL wr_bus_idle got=%h/%h exp=0", usi_adrs, usi_wd); end
    tick();
    n_tests++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL wr_done got=%b exp=10", {cmd_ready, rsp_valid}); end
  endtask

  task automatic test_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_id = 4'd3; cmd_adrs = 16'h0010; cmd_wd = 32'hFFFF_FFFF;
    tick();
    cmd_valid = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_tests++; if (usi_adrs !== 32'h8003_0010) begin n_fail++; $display("FAIL rd_adrs_c%0d got=%h exp=80030010", k, usi_adrs); end
      n_tests++; if ({usi_wd, rsp_valid} !== 33'h0) begin n_fail++; $display("FAIL rd_wait_c%0d got=%h/%b exp=0", k, usi_wd, rsp_valid); end
      if (k == 4) begin usi_red = 1'b1; usi_rd = 32'h35; end
      tick();
    end
    usi_red = 1'b0; usi_rd = 32'h0;
    n_tests++; if ({rsp_valid, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL rd_rsp got=%b exp=10", {rsp_valid, rsp_err}); end
    n_tests++; if (rsp_rd !== 32'h35) begin n_fail++; $display("FAIL rd_data got=%h exp=35", rsp_rd); end
    n_tests++; if (usi_adrs !== 32'h0) begin n_fail++; $display("FAIL rd_bus_idle got=%h exp=0", usi_adrs); end
    tick();
    n_tests++; if ({rsp_valid, cmd_ready} !== 2'b01) begin n_fail++; $display("FAIL rd_pulse got=%b exp=01", {rsp_valid, cmd_ready}); end
    n_tests++; if (rsp_rd !== 32'h35) begin n_fail++; $display("FAIL rd_hold got=%h exp=35", rsp_rd); end
  endtask

  task automatic test_red_ignored();
    usi_red = 1'b1; usi_rd = 32'hAAAA;
    tick();
    n_tests++; if ({rsp_valid, rsp_rd} !== {1'b0, 32'h35}) begin n_fail++; $display("FAIL idle_red got=%b/%h exp=0/35", rsp_valid, rsp_rd); end
    usi_rd = 32'hBBBB;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_id = 4'd5; cmd_adrs = 16'h0020;
    tick();
    cmd_valid = 1'b0; usi_red = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_tests++; if ({rsp_valid, usi_adrs} !== {1'b0, 32'h8005_0020}) begin n_fail++; $display("FAIL acc_red_c%0d got=%b/%h exp=0/80050020", k, rsp_valid, usi_adrs); end
      if (k == 4) begin usi_red = 1'b1; usi_rd = 32'hC0DE; end
      tick();
    end
    usi_red = 1'b0;
    n_tests++; if ({rsp_valid, rsp_err, rsp_rd} !== {2'b10, 32'hC0DE}) begin n_fail++; $display("FAIL acc_red_rsp got=%b%b/%h exp=10/c0de", rsp_valid, rsp_err, rsp_rd); end
    tick();
  endtask

  task automatic test_timeout();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_id = 4'd1; cmd_adrs = 16'h0004;
    tick();
    cmd_valid = 1'b0;
`ifdef USI_CSR_MASTER_TIMEOUT_EN
    for (int k = 1; k <= 8; k++) begin
      n_tests++; if ({rsp_valid, usi_adrs} !== {1'b0, 32'h8001_0004}) begin n_fail++; $display("FAIL to_wait_c%0d got=%b/%h exp=0/80010004", k, rsp_valid, usi_adrs); end
      tick();
    end
    n_tests++; if ({rsp_valid, rsp_err} !== 2'b11) begin n_fail++; $display("FAIL to_rsp got=%b exp=11", {rsp_valid, rsp_err}); end
    n_tests++; if ({rsp_rd, usi_adrs} !== 64'h0) begin n_fail++; $display("FAIL to_data got=%h/%h exp=0/0", rsp_rd, usi_adrs); end
    tick();
    n_tests++; if ({cmd_ready, rsp_valid, rsp_err} !== 3'b101) begin n_fail++; $display("FAIL to_after got=%b exp=101", {cmd_ready, rsp_valid, rsp_err}); end
`else
    for (int k = 1; k <= 20; k++) begin
      n_tests++; if ({rsp_valid, rsp_err, usi_adrs} !== {2'b00, 32'h8001_0004}) begin n_fail++; $display("FAIL nt_wait_c%0d got=%b%b/%h exp=00/80010004", k, rsp_valid, rsp_err, usi_adrs); end
      tick();
    end
    usi_red = 1'b1; usi_rd = 32'h77;
    tick();
    usi_red = 1'b0;
    n_tests++; if ({rsp_valid, rsp_err, rsp_rd} !== {2'b10, 32'h77}) begin n_fail++; $display("FAIL nt_rsp got=%b%b/%h exp=10/77", rsp_valid, rsp_err, rsp_rd); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_read();
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_id = 4'd2; cmd_adrs = 16'h0008;
    tick();
    cmd_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    n_tests++; if ({cmd_ready, rsp_valid, rsp_err} !== 3'b000) begin n_fail++; $display("FAIL mrst_ctl got=%b exp=000", {cmd_ready, rsp_valid, rsp_err}); end
    n_tests++; if ({rsp_rd, usi_wd, usi_adrs} !== 96'h0) begin n_fail++; $display("FAIL mrst_data got=%h/%h/%h exp=0", rsp_rd, usi_wd, usi_adrs); end
    usi_red = 1'b1; usi_rd = 32'h1234;
    tick();
    usi_red = 1'b0;
    rst_n = 1'b1;
    tick();
    n_tests++; if ({cmd_ready, rsp_valid} !== 2'b10) begin n_fail++; $display("FAIL mrst_release got=%b exp=10", {cmd_ready, rsp_valid}); end
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_id = 4'd9; cmd_adrs = 16'hBEEF; cmd_wd = 32'hDEAD_0001;
    tick();
    cmd_valid = 1'b0;
    n_tests++; if ({usi_adrs, usi_wd} !== {32'h4009_BEEF, 32'hDEAD_0001}) begin n_fail++; $display("FAIL mrst_wr_bus got=%h/%h exp=4009beef/dead0001", usi_adrs, usi_wd); end
    tick();
    n_tests++; if ({rsp_valid, rsp_err, rsp_rd} !== {2'b10, 32'h0}) begin n_fail++; $display("FAIL mrst_wr_rsp got=%b%b/%h exp=10/0", rsp_valid, rsp_err, rsp_rd); end
    tick();
  endtask

  task automatic test_back_to_back();
    int acc = 0;
    int rsp = 0;
    int last = 0;
    logic hs;
    cmd_write = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cmd_valid = (acc < 4);
      cmd_id    = 4'(acc + 1);
      cmd_adrs  = 16'h0100 + 16'(acc);
      cmd_wd    = 32'hA000_0000 + 32'(acc);
      hs        = cmd_valid & cmd_ready;
      tick();
      if (rsp_valid) rsp++;
      if (hs) begin
        n_tests++; if ({usi_adrs, usi_wd} !== {2'b01, 10'd0, 4'(acc + 1), 16'h0100 + 16'(acc), 32'hA000_0000 + 32'(acc)}) begin n_fail++; $display("FAIL b2b_bus%0d got=%h/%h", acc, usi_adrs, usi_wd); end
        if (acc > 0) begin
          n_tests++; if (c - last != 3) begin n_fail++; $display("FAIL b2b_gap%0d got=%0d exp=3", acc, c - last); end
        end
        last = c;
        acc++;
      end
    end
    cmd_valid = 1'b0;
    n_tests++; if (acc != 4) begin n_fail++; $display("FAIL b2b_accepts got=%0d exp=4", acc); end
    n_tests++; if (rsp != 4) begin n_fail++; $display("FAIL b2b_rsps got=%0d exp=4", rsp); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_red_ignored();
    test_timeout();
    test_reset_mid_read();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
